reg_dump_uart_tx: RTL and testbench

//  Reads the CPU register file outputs and sends them out over a UART line (8N1) for debug.
//  A single dump_start pulse sends NUM_REGS registers, each as 4 bytes, MSB first.
//  It selects registers through an index/data port; a combinational mux in the top level

---
 rtl/debug_pkg.sv | 38 +++
 rtl/uart_tx_byte.sv | 94 +++++++++
 rtl/reg_dump_uart_tx.sv | 129 ++++++++++++
 tb/tb_reg_dump_uart_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debug_pkg
//  Purpose  : Shared constants, state encodings and byte-select helper for
//             the register-dump UART transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package debug_pkg;

    // 50 MHz pipeline clock / 115200 baud
    localparam int c_CLKS_PER_BIT_DEFAULT = 434;
    localparam int c_BYTES_PER_REG        = 4;

    // State encodings shared by the sequencer (IDLE/LOAD/SEND/FIN)
    // and the byte serialiser (IDLE/START/DATA/STOP).
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_START = 3'd2;
    localparam logic [2:0] c_ST_DATA  = 3'd3;
    localparam logic [2:0] c_ST_STOP  = 3'd4;
    localparam logic [2:0] c_ST_SEND  = 3'd5;
    localparam logic [2:0] c_ST_FIN   = 3'd6;

    // Byte idx of a 32-bit word, most significant byte first (idx 0 = [31:24]).
    function automatic logic [7:0] reg_byte(input logic [31:0] i_word,
                                            input logic [1:0]  i_idx);
        logic [7:0] r;
        case (i_idx)
            2'd0:    r = i_word[31:24];
            2'd1:    r = i_word[23:16];
            2'd2:    r = i_word[15:8];
            default: r = i_word[7:0];
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_byte
//  Purpose  : 8N1 byte serialiser. A tx_start accepted in the last cycle of
//             a stop bit chains the next frame with no idle gap.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done
);

    localparam int                 c_CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               w_bit_end;
    logic               w_load;

    assign w_bit_end = (r_baud == c_BAUD_LAST);
    // A new byte is taken when idle or exactly as the current stop bit ends.
    assign w_load    = tx_start && ((r_state == c_ST_IDLE) ||
                                    ((r_state == c_ST_STOP) && w_bit_end));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: advance one frame phase per completed bit period
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (tx_start) w_next_state = c_ST_START;
            c_ST_START: if (w_bit_end) w_next_state = c_ST_DATA;
            c_ST_DATA:  if (w_bit_end && (r_bit == 3'd7)) w_next_state = c_ST_STOP;
            c_ST_STOP:  if (w_bit_end) w_next_state = tx_start ? c_ST_START : c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Baud counter, bit counter and shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (w_load) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= tx_data;
        end else if (r_state == c_ST_IDLE) begin
            r_baud  <= '0;
        end else if (w_bit_end) begin
            r_baud <= '0;
            if (r_state == c_ST_DATA) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end else begin
            r_baud <= r_baud + c_CNT_W'(1);
        end
    end

    // Line output and end-of-frame strobe
    always_comb begin
        tx      = 1'b1;
        tx_done = 1'b0;
        case (r_state)
            c_ST_START: tx = 1'b0;
            c_ST_DATA:  tx = r_shift[0];
            c_ST_STOP:  tx_done = w_bit_end;
            default:    tx = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/reg_dump_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_uart_tx
//  Purpose  : Dumps NUM_REGS 32-bit registers (4 bytes each, MSB first) over
//             an 8N1 UART line on a single dump_start pulse.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_uart_tx
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dump_start,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] c_LAST_SEL  = 5'(NUM_REGS - 1);
    localparam logic [1:0] c_LAST_BYTE = 2'(c_BYTES_PER_REG - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [4:0]  r_sel;
    logic [1:0]  r_byte;
    logic [31:0] r_sh;
    logic        w_tx_start;
    logic [7:0]  w_tx_data;
    logic        w_tx_done;
    logic        w_reg_end;

    assign w_reg_end = w_tx_done && (r_byte == c_LAST_BYTE);
    assign reg_sel   = r_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: sequence registers and bytes around the serialiser
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (dump_start) w_next_state = c_ST_LOAD;
            c_ST_LOAD: w_next_state = c_ST_SEND;
            c_ST_SEND: if (w_reg_end) w_next_state = (r_sel < c_LAST_SEL) ? c_ST_LOAD : c_ST_FIN;
            c_ST_FIN:  w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Register index, byte index and the register snapshot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel  <= '0;
            r_byte <= '0;
            r_sh   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (dump_start) begin
                        r_sel  <= '0;
                        r_byte <= '0;
                    end
                end
                c_ST_LOAD: r_sh <= reg_data;
                c_ST_SEND: begin
                    if (w_tx_done) begin
                        if (r_byte != c_LAST_BYTE) begin
                            r_byte <= r_byte + 2'd1;
                        end else if (r_sel < c_LAST_SEL) begin
                            r_sel  <= r_sel + 5'd1;
                            r_byte <= '0;
                        end
                    end
                end
                c_ST_FIN: begin
                    r_sel  <= '0;
                    r_byte <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs: serialiser feed, busy and done
    always_comb begin
        w_tx_start = 1'b0;
        w_tx_data  = reg_byte(r_sh, r_byte + 2'd1);
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            c_ST_LOAD: begin
                // Same value that r_sh captures on this edge.
                w_tx_start = 1'b1;
                w_tx_data  = reg_data[31:24];
                busy       = 1'b1;
            end
            c_ST_SEND: begin
                w_tx_start = w_tx_done && (r_byte != c_LAST_BYTE);
                busy       = 1'b1;
            end
            c_ST_FIN: done = 1'b1;
            default: ;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .tx_start (w_tx_start),
        .tx_data  (w_tx_data),
        .tx       (tx),
        .tx_done  (w_tx_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_dump_uart_tx
//  Purpose  : Self-checking bench for reg_dump_uart_tx (CLKS_PER_BIT=4),
//             one 2-register and one 32-register instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_dump_uart_tx;

    localparam int c_CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start2, start32;
    logic [4:0]  sel2, sel32;
    logic [31:0] data2, data32;
    logic        tx2, tx32, busy2, busy32, done2, done32;
    logic [31:0] regs2 [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // monitor state / results
    byte unsigned rx2[$];
    byte unsigned rx32[$];
    int  done2_cnt = 0, done32_cnt = 0, done2_cyc = 0, done32_cyc = 0;
    logic done2_busy, done32_busy;
    int  ferr2 = 0, ferr32 = 0;

    always #5 clk = ~clk;

    assign data2  = regs2[sel2[0]];
    assign data32 = 32'(sel32) * 32'h01010101;

    reg_dump_uart_tx #(.CLKS_PER_BIT(c_CPB), .NUM_REGS(2)) u_dut2 (
        .clk(clk), .reset(rst), .dump_start(start2), .reg_sel(sel2),
        .reg_data(data2), .tx(tx2), .busy(busy2), .done(done2));

    reg_dump_uart_tx #(.CLKS_PER_BIT(c_CPB), .NUM_REGS(32)) u_dut32 (
        .clk(clk), .reset(rst), .dump_start(start32), .reg_sel(sel32),
        .reg_data(data32), .tx(tx32), .busy(busy32), .done(done32));

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // UART receivers: c counts negedges from the first low sample of the
    // start bit; data bit i is taken at c = 6 + 4*i, stop bit at c = 38.
    initial begin
        bit   act2 = 0, act32 = 0;
        int   c2 = 0, c32 = 0;
        logic [7:0] sh2 = '0, sh32 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                act2 = 0; act32 = 0;
            end else begin
                if (!act2) begin
                    if (tx2 == 1'b0) begin act2 = 1; c2 = 0; end
                end else begin
                    c2++;
                    if (c2 >= 6 && c2 <= 34 && ((c2 - 2) % c_CPB) == 0) sh2 = {tx2, sh2[7:1]};
                    if (c2 == 38) begin
                        if (tx2 !== 1'b1) ferr2++;
                        rx2.push_back(sh2);
                        act2 = 0;
                    end
                end
                if (!act32) begin
                    if (tx32 == 1'b0) begin act32 = 1; c32 = 0; end
                end else begin
                    c32++;
                    if (c32 >= 6 && c32 <= 34 && ((c32 - 2) % c_CPB) == 0) sh32 = {tx32, sh32[7:1]};
                    if (c32 == 38) begin
                        if (tx32 !== 1'b1) ferr32++;
                        rx32.push_back(sh32);
                        act32 = 0;
                    end
                end
            end
            if (done2 === 1'b1) begin done2_cnt++; done2_cyc = cyc; done2_busy = busy2; end
            if (done32 === 1'b1) begin done32_cnt++; done32_cyc = cyc; done32_busy = busy32; end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] r0;
        logic [31:0] r1;
        int          start_len;   // cycles dump_start is held high
        int          poke_at;     // extra 1-cycle start at this offset (-1 none)
        int          chg_at;      // offset at which reg0 changes (-1 none)
        logic [31:0] chg_val;
        logic [63:0] exp;         // expected 8 bytes, first byte in [63:56]
    } vec_t;

    vec_t vecs [5];

    // One 2-register dump; offset k counts cycles from the start cycle (k=0).
    // FIN falls at k=323, i.e. the 324th cycle counted inclusively.
    task automatic run_vec(input int idx);
        vec_t        v;
        int          s, k;
        logic [63:0] e;
        v = vecs[idx];
        rx2.delete();
        done2_cnt = 0;
        ferr2     = 0;
        regs2[0]  = v.r0;
        regs2[1]  = v.r1;
        @(posedge clk); #1;
        s = cyc;
        start2 = 1'b1;
        k = 0;
        while (done2_cnt == 0 && k < 2000) begin
            @(posedge clk); #1;
            k = cyc - s;
            start2 = (k < v.start_len) || (k == v.poke_at);
            if (k == v.chg_at) regs2[0] = v.chg_val;
        end
        start2 = 1'b0;
        chk({v.name, " done_seen"}, 64'(done2_cnt), 64'd1);
        chk({v.name, " done_cycle"}, 64'(done2_cyc - s + 1), 64'd324);
        chk({v.name, " busy_at_done"}, 64'(done2_busy), 64'd0);
        repeat (400) @(posedge clk);
        #1;
        chk({v.name, " byte_count"}, 64'(rx2.size()), 64'd8);
        chk({v.name, " done_count"}, 64'(done2_cnt), 64'd1);
        chk({v.name, " framing"}, 64'(ferr2), 64'd0);
        e = v.exp;
        for (int j = 0; j < 8; j++) begin
            if (j < rx2.size())
                chk($sformatf("%s byte%0d", v.name, j), 64'(rx2[j]), 64'(e[63-8*j -: 8]));
        end
    endtask

    initial begin
        int s32, k;
        vecs[0] = '{"basic",     32'h12345678, 32'hDEADBEEF, 1, -1,  -1, 32'h0, 64'h12345678_DEADBEEF};
        vecs[1] = '{"hold_poke", 32'h12345678, 32'hDEADBEEF, 3, 150, -1, 32'h0, 64'h12345678_DEADBEEF};
        vecs[2] = '{"snapshot",  32'h000000FF, 32'h01020304, 1, -1,  60, 32'h0, 64'h000000FF_01020304};
        vecs[3] = '{"pattern",   32'hA5C30F01, 32'h80000001, 1, -1,  -1, 32'h0, 64'hA5C30F01_80000001};
        vecs[4] = '{"fin_poke",  32'h00FF00FF, 32'hC0FFEE11, 1, 323, -1, 32'h0, 64'h00FF00FF_C0FFEE11};

        rst = 1'b1; start2 = 1'b0; start32 = 1'b0;
        regs2[0] = '0; regs2[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {58'd0, tx2, busy2, done2, 1'b0, sel2 == 5'd0, tx32},
                           {58'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle after reset
        repeat (100) begin
            @(negedge clk);
            chk("idle_hold", {50'd0, tx2, busy2, done2, sel2, tx32, busy32, done32, sel32},
                             {50'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0});
        end

        for (int i = 0; i < 5; i++) run_vec(i);

        // Reset 50 cycles into a dump abandons it without a done pulse
        rx2.delete();
        done2_cnt = 0;
        regs2[0] = 32'h12345678; regs2[1] = 32'hDEADBEEF;
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_tx", 64'(tx2), 64'd1);
        chk("abort_busy", 64'(busy2), 64'd0);
        chk("abort_sel", 64'(sel2), 64'd0);
        repeat (400) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done2_cnt), 64'd0);
        run_vec(0);

        // Full 32-register dump
        rx32.delete();
        done32_cnt = 0;
        ferr32 = 0;
        @(posedge clk); #1;
        s32 = cyc;
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        k = 1;
        while (done32_cnt == 0 && k < 7000) begin
            @(posedge clk); #1;
            k = cyc - s32;
        end
        chk("r32 done_seen", 64'(done32_cnt), 64'd1);
        chk("r32 done_cycle", 64'(done32_cyc - s32 + 1), 64'd5154);
        chk("r32 busy_at_done", 64'(done32_busy), 64'd0);
        repeat (50) @(posedge clk);
        #1;
        chk("r32 byte_count", 64'(rx32.size()), 64'd128);
        chk("r32 framing", 64'(ferr32), 64'd0);
        chk("r32 done_count", 64'(done32_cnt), 64'd1);
        for (int j = 0; j < 128; j++) begin
            if (j < rx32.size())
                chk($sformatf("r32 byte%0d", j), 64'(rx32[j]), 64'(j / 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
